// File: rtl/bit_serial_alu.sv
// rtl/bit_serial_alu.sv - bit-serial AND/OR/ADD/SLT ALU, one bit per clock, LSB first
module bit_serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             ainvert,
  input  logic             binvert,
  input  logic [1:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             ainv_q, binv_q;
  logic [1:0]       s_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             x, y, sum, carry_nx, op_bit;

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    x        = a_sh[0] ^ ainv_q;
    y        = b_sh[0] ^ binv_q;
    sum      = x ^ y ^ carry;
    carry_nx = (x & y) | (x & carry) | (y & carry);
    case (s_q)
      2'b00:   op_bit = x & y;
      2'b01:   op_bit = x | y;
      2'b10:   op_bit = sum;
      default: op_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      ainv_q <= 1'b0;
      binv_q <= 1'b0;
      s_q    <= 2'b00;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            ainv_q <= ainvert;
            binv_q <= binvert;
            s_q    <= s;
            carry  <= cin;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= carry_nx;
          if (last) begin
            cnt  <= '0;
            cout <= carry_nx;
            // SLT reports the sign of a-b from the last sum bit, no overflow fix-up
            if (s_q == 2'b11) result <= {{(WIDTH-1){1'b0}}, sum};
            else              result <= {op_bit, result[WIDTH-1:1]};
          end else begin
            cnt    <= cnt + CW'(1);
            result <= {op_bit, result[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu.sv
// tb/tb_bit_serial_alu.sv - table-driven scoreboard bench for bit_serial_alu
module tb_bit_serial_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0, ainvert = 1'b0, binvert = 1'b0;
  logic [1:0]   s = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout;

  bit_serial_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .ainvert(ainvert), .binvert(binvert), .s(s),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, ai, bi;
    logic [1:0]   s;
    logic [W-1:0] r;
    logic         co;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic         co;
    int           t;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0, n_err = 0, n_sent = 0, n_done = 0, cyc = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic model(input vec_t v, output logic [W-1:0] r, output logic co);
    logic [W-1:0] x, y;
    logic [W:0]   sm;
    x  = v.ai ? ~v.a : v.a;
    y  = v.bi ? ~v.b : v.b;
    sm = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, v.cin};
    co = sm[W];
    case (v.s)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = sm[W-1:0];
      default: r = {{(W-1){1'b0}}, sm[W-1]};
    endcase
  endtask

  // Monitor: compare on each result handshake and check latency on out_valid rise
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) check("unexpected_out_valid", 1, 0);
        else check("latency", 64'(cyc - q[0].t), 64'(W));
      end
      if (out_valid && out_ready) begin
        if (q.size() != 0) begin
          check("result", result, q[0].r);
          check("cout", cout, q[0].co);
          void'(q.pop_front());
          n_done++;
        end
      end
    end
    prev_ov <= out_valid;
  end

  task automatic send(input vec_t v);
    bit ok = 0;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; ainvert = v.ai; binvert = v.bi; s = v.s;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (in_ready) begin
        q.push_back('{r: v.r, co: v.co, t: cyc + 1});
        n_sent++;
        ok = 1;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready=1");
    end
    // Scramble inputs after acceptance; the in-flight op must not notice
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = ~cin; ainvert = ~ainvert; binvert = ~binvert; s = ~s;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(q.size()), 0);
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    tbl[0]  = '{32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 2'b10, 32'h0,         1'b1};
    tbl[1]  = '{32'h5,         32'h7,         1'b1, 1'b0, 1'b1, 2'b10, 32'hFFFF_FFFE, 1'b0};
    tbl[2]  = '{32'h5,         32'h7,         1'b1, 1'b0, 1'b1, 2'b11, 32'h1,         1'b0};
    tbl[3]  = '{32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 1'b0, 1'b0, 2'b00, 32'h00F0_1200, 1'b1};
    tbl[4]  = '{32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 1'b0, 1'b0, 2'b01, 32'hFFF0_FF34, 1'b1};
    tbl[5]  = '{32'h0000_FFFF, 32'h00FF_00FF, 1'b0, 1'b1, 1'b1, 2'b00, 32'hFF00_0000, 1'b1};
    tbl[6]  = '{32'h3,         32'h4,         1'b0, 1'b0, 1'b0, 2'b10, 32'h7,         1'b0};
    tbl[7]  = '{32'h7,         32'h5,         1'b1, 1'b0, 1'b1, 2'b11, 32'h0,         1'b1};
    tbl[8]  = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 2'b10, 32'h8000_0000, 1'b0};
    tbl[9]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 2'b11, 32'h1,         1'b0};
    tbl[10] = '{32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 2'b10, 32'h1,         1'b0};
    tbl[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) send(tbl[i]);
    drain();

    for (int i = 0; i < 8; i++) begin
      v.a = $urandom; v.b = $urandom; v.cin = 1'($urandom);
      v.ai = 1'($urandom); v.bi = 1'($urandom); v.s = 2'($urandom);
      model(v, v.r, v.co);
      send(v);
    end
    drain();

    // Backpressure: hold the result for 10 cycles with a competing bundle offered
    out_ready = 1'b0;
    send(tbl[0]);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    a = 32'h1234; b = 32'h1; s = 2'b10; cin = 1'b0; ainvert = 1'b0; binvert = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", result, 32'h0);
      check("stall_cout", cout, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(tbl[6]);
    drain();

    // Reset in the middle of an ADD: partial result is discarded
    send(tbl[0]);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_cout", cout, 0);
    n_sent = n_sent - q.size();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(tbl[6]);
    drain();

    check("completed_ops", 64'(n_done), 64'(n_sent));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
